// File: rtl/uart_tx_serializer_if.sv
// Parallel-side request/config signals and the serial line/busy status of the UART transmitter.
interface uart_tx_serializer_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA_TX;
  logic                  DATA_VALID_TX;
  logic                  PAR_EN_TX;
  logic                  PAR_TYP_TX;
  logic                  TX_OUT_TX;
  logic                  BUSY_TX;

  modport master (
    output P_DATA_TX, DATA_VALID_TX, PAR_EN_TX, PAR_TYP_TX,
    input  TX_OUT_TX, BUSY_TX
  );

  modport slave (
    input  P_DATA_TX, DATA_VALID_TX, PAR_EN_TX, PAR_TYP_TX,
    output TX_OUT_TX, BUSY_TX
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmitter clocked at the bit rate: start, LSB-first data, optional parity, stop.
// Line and busy come straight from flops; next values are computed one cycle ahead.
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                 CLK_TX,
  input  logic                 RST_TX,
  uart_tx_serializer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state, state_nxt;
  logic [CNT_WIDTH-1:0]  cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] shift_q, shift_nxt;
  logic                  par_en_q, par_typ_q;
  logic                  tx_q, tx_nxt;
  logic                  busy_q, busy_nxt;
  logic                  accept;

  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  // Next state plus next line/busy values, so both outputs can be registered.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    shift_nxt = shift_q;
    tx_nxt    = 1'b1;
    busy_nxt  = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.DATA_VALID_TX) begin
          accept    = 1'b1;
          state_nxt = START;
          shift_nxt = bus.P_DATA_TX;
          cnt_nxt   = '0;
          tx_nxt    = 1'b0;
          busy_nxt  = 1'b1;
        end
      end
      START: begin
        state_nxt = DATA;
        cnt_nxt   = '0;
        tx_nxt    = shift_q[0];
        shift_nxt = shift_q >> 1;
        busy_nxt  = 1'b1;
      end
      DATA: begin
        busy_nxt = 1'b1;
        if (cnt == CNT_WIDTH'(DATA_WIDTH - 1)) begin
          cnt_nxt = '0;
          if (par_en_q) begin
            state_nxt = PARITY;
            tx_nxt    = parity_bit(data_q, par_typ_q);
          end else begin
            state_nxt = STOP;
          end
        end else begin
          cnt_nxt   = cnt + CNT_WIDTH'(1);
          tx_nxt    = shift_q[0];
          shift_nxt = shift_q >> 1;
        end
      end
      PARITY: begin
        state_nxt = STOP;
        busy_nxt  = 1'b1;
      end
      STOP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK_TX or negedge RST_TX) begin
    if (!RST_TX) begin
      state     <= IDLE;
      cnt       <= '0;
      data_q    <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      shift_q <= shift_nxt;
      tx_q    <= tx_nxt;
      busy_q  <= busy_nxt;
      if (accept) begin
        data_q    <= bus.P_DATA_TX;
        par_en_q  <= bus.PAR_EN_TX;
        par_typ_q <= bus.PAR_TYP_TX;
      end
    end
  end

  assign bus.TX_OUT_TX = tx_q;
  assign bus.BUSY_TX   = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: fixed frame table, back-to-back, reset abort and random frames
// decoded by a receiver-style model.
module tb_uart_tx_serializer;
  localparam int DW = 8;

  logic CLK_TX = 1'b0;
  logic RST_TX = 1'b0;
  always #5 CLK_TX = ~CLK_TX;

  uart_tx_serializer_if #(.DATA_WIDTH(DW)) bus ();

  uart_tx_serializer #(.DATA_WIDTH(DW), .CNT_WIDTH(4)) dut (
    .CLK_TX (CLK_TX),
    .RST_TX (RST_TX),
    .bus    (bus)
  );

  typedef struct {
    logic [7:0]  data;
    logic        en;
    logic        typ;
    logic [0:10] line;
    int          len;
    bit          scramble;
  } vec_t;

  int total  = 0;
  int passed = 0;
  bit exp_tx[$];
  bit exp_busy[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Expected line for one frame, built from the frame rules.
  task automatic push_frame(input logic [7:0] d, input logic en, input logic typ);
    exp_tx.push_back(1'b0); exp_busy.push_back(1'b1);
    for (int i = 0; i < DW; i++) begin
      exp_tx.push_back(d[i]); exp_busy.push_back(1'b1);
    end
    if (en) begin
      exp_tx.push_back((^d) ^ typ); exp_busy.push_back(1'b1);
    end
    exp_tx.push_back(1'b1); exp_busy.push_back(1'b1);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    @(posedge CLK_TX); #1;
    bus.P_DATA_TX = v.data; bus.PAR_EN_TX = v.en; bus.PAR_TYP_TX = v.typ;
    bus.DATA_VALID_TX = 1'b1;
    @(posedge CLK_TX); #1;
    bus.DATA_VALID_TX = 1'b0;
    for (int i = 0; i < v.len; i++) begin
      @(negedge CLK_TX);
      chk($sformatf("%s tx[%0d]", name, i), bus.TX_OUT_TX, v.line[i]);
      chk($sformatf("%s busy[%0d]", name, i), bus.BUSY_TX, 1'b1);
      if (v.scramble) begin
        bus.P_DATA_TX     = 8'($urandom);
        bus.PAR_EN_TX     = 1'($urandom);
        bus.PAR_TYP_TX    = 1'($urandom);
        bus.DATA_VALID_TX = (i < v.len - 1) ? 1'($urandom) : 1'b0;
      end
    end
    @(negedge CLK_TX);
    chk({name, " idle tx"}, bus.TX_OUT_TX, 1'b1);
    chk({name, " idle busy"}, bus.BUSY_TX, 1'b0);
  endtask

  // Receiver-style model: collect the busy window and decode it as a UART frame.
  task automatic rx_frame(input logic [7:0] d, input logic en, input logic typ, input int idx);
    bit   bits[$];
    logic [7:0] word;
    int   n;
    @(posedge CLK_TX); #1;
    bus.P_DATA_TX = d; bus.PAR_EN_TX = en; bus.PAR_TYP_TX = typ;
    bus.DATA_VALID_TX = 1'b1;
    @(posedge CLK_TX); #1;
    bus.DATA_VALID_TX = 1'b0;
    bus.P_DATA_TX = 8'($urandom); bus.PAR_EN_TX = 1'($urandom); bus.PAR_TYP_TX = 1'($urandom);
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK_TX);
      if (!bus.BUSY_TX) break;
      bits.push_back(bus.TX_OUT_TX);
    end
    n = bits.size();
    chk($sformatf("rnd%0d frame len", idx), n, DW + 2 + (en ? 1 : 0));
    chk($sformatf("rnd%0d idle tx", idx), bus.TX_OUT_TX, 1'b1);
    if (n == DW + 2 + (en ? 1 : 0)) begin
      word = '0;
      for (int i = 0; i < DW; i++) word[i] = bits[1 + i];
      chk($sformatf("rnd%0d start", idx), bits[0], 1'b0);
      chk($sformatf("rnd%0d word", idx), word, d);
      if (en) chk($sformatf("rnd%0d parity ok", idx), (^word) ^ bits[DW + 1], typ);
      chk($sformatf("rnd%0d stop", idx), bits[n - 1], 1'b1);
    end
  endtask

  vec_t vecs[6];

  initial begin
    bus.P_DATA_TX = '0; bus.DATA_VALID_TX = 1'b0; bus.PAR_EN_TX = 1'b0; bus.PAR_TYP_TX = 1'b0;

    vecs[0] = '{8'hA5, 1'b0, 1'b0, 11'b0_10100101_1_1, 10, 1'b0};
    vecs[1] = '{8'hA5, 1'b1, 1'b0, 11'b0_10100101_0_1, 11, 1'b0};
    vecs[2] = '{8'hA5, 1'b1, 1'b1, 11'b0_10100101_1_1, 11, 1'b0};
    vecs[3] = '{8'h07, 1'b1, 1'b0, 11'b0_11100000_1_1, 11, 1'b0};
    vecs[4] = '{8'h81, 1'b1, 1'b1, 11'b0_10000001_1_1, 11, 1'b1};
    vecs[5] = '{8'hFF, 1'b1, 1'b1, 11'b0_11111111_1_1, 11, 1'b0};

    repeat (2) @(negedge CLK_TX);
    chk("reset tx", bus.TX_OUT_TX, 1'b1);
    chk("reset busy", bus.BUSY_TX, 1'b0);
    RST_TX = 1'b1;
    @(negedge CLK_TX);
    chk("post-reset idle tx", bus.TX_OUT_TX, 1'b1);

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back with valid held high; word switched during the first frame.
    exp_tx.delete(); exp_busy.delete();
    push_frame(8'h3C, 1'b0, 1'b0);
    exp_tx.push_back(1'b1); exp_busy.push_back(1'b0);
    push_frame(8'hC3, 1'b0, 1'b0);
    exp_tx.push_back(1'b1); exp_busy.push_back(1'b0);
    exp_tx.push_back(1'b1); exp_busy.push_back(1'b0);
    @(posedge CLK_TX); #1;
    bus.P_DATA_TX = 8'h3C; bus.PAR_EN_TX = 1'b0; bus.PAR_TYP_TX = 1'b0; bus.DATA_VALID_TX = 1'b1;
    @(posedge CLK_TX); #1;
    bus.P_DATA_TX = 8'hC3;
    for (int j = 0; j < exp_tx.size(); j++) begin
      @(negedge CLK_TX);
      chk($sformatf("b2b tx[%0d]", j), bus.TX_OUT_TX, exp_tx[j]);
      chk($sformatf("b2b busy[%0d]", j), bus.BUSY_TX, exp_busy[j]);
      if (j >= 11) bus.DATA_VALID_TX = (j == 14 || j == 16);
    end
    bus.DATA_VALID_TX = 1'b0;

    // Asynchronous reset in the middle of a 0x55 frame.
    @(posedge CLK_TX); #1;
    bus.P_DATA_TX = 8'h55; bus.PAR_EN_TX = 1'b1; bus.DATA_VALID_TX = 1'b1;
    @(posedge CLK_TX); #1;
    bus.DATA_VALID_TX = 1'b0;
    repeat (4) @(negedge CLK_TX);
    chk("pre-abort busy", bus.BUSY_TX, 1'b1);
    #1 RST_TX = 1'b0;
    #1;
    chk("abort tx", bus.TX_OUT_TX, 1'b1);
    chk("abort busy", bus.BUSY_TX, 1'b0);
    @(negedge CLK_TX);
    RST_TX = 1'b1;
    for (int j = 0; j < 14; j++) begin
      @(negedge CLK_TX);
      chk($sformatf("after-abort tx[%0d]", j), bus.TX_OUT_TX, 1'b1);
      chk($sformatf("after-abort busy[%0d]", j), bus.BUSY_TX, 1'b0);
    end

    for (int r = 0; r < 40; r++) begin
      rx_frame(8'($urandom), 1'($urandom), 1'($urandom), r);
      repeat ($urandom_range(0, 3)) @(posedge CLK_TX);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
